// File: rtl/keypad_ctrl.sv
// rtl/keypad_ctrl.sv - 4x4 matrix keypad scanner with debounce and two-digit history
module keypad_ctrl #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CYC = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] columns,
    output logic [3:0] rows,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

    localparam logic [7:0]  DWELL_LAST = 8'(SCAN_DIV - 1);
    localparam logic [20:0] DEB_LAST   = 21'(DEBOUNCE_CYC - 1);

    state_t      state;
    logic [3:0]  sync1, sync2;
    logic [3:0]  col_s;
    logic [3:0]  cap_pat;
    logic [1:0]  cap_row;
    logic [7:0]  dwell;
    logic [20:0] deb;
    logic [3:0]  code;
    logic [3:0]  rows_next;

    assign col_s     = sync2;
    assign rows_next = {rows[0], rows[3:1]};

    function automatic logic [1:0] row_index(input logic [3:0] r);
        case (r)
            4'b1000: row_index = 2'd0;
            4'b0100: row_index = 2'd1;
            4'b0010: row_index = 2'd2;
            default: row_index = 2'd3;
        endcase
    endfunction

    // Leftmost low column (col0 = bit3) wins when several are pressed.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [3:0] pat);
        logic [1:0] c;
        casez (pat)
            4'b0???: c = 2'd0;
            4'b10??: c = 2'd1;
            4'b110?: c = 2'd2;
            default: c = 2'd3;
        endcase
        case ({r, c})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;
            4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;
            4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;
            4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;
            4'hE: key_map = 4'hF;  default: key_map = 4'hD;
        endcase
    endfunction

    assign code = key_map(cap_row, cap_pat);

    // Counters only increment below their terminal value, so they can never wrap.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= SCAN;
            sync1     <= 4'hF;
            sync2     <= 4'hF;
            rows      <= 4'b1000;
            cap_pat   <= 4'hF;
            cap_row   <= 2'd0;
            dwell     <= 8'd0;
            deb       <= 21'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            digit_new <= 4'd0;
            digit_old <= 4'd0;
        end else begin
            sync1     <= columns;
            sync2     <= sync1;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (dwell >= DWELL_LAST) begin
                        if (col_s != 4'hF) begin
                            state   <= DEBOUNCE;
                            cap_pat <= col_s;
                            cap_row <= row_index(rows);
                            deb     <= 21'd0;
                        end else begin
                            rows  <= rows_next;
                            dwell <= 8'd0;
                        end
                    end else begin
                        dwell <= dwell + 8'd1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s == cap_pat) begin
                        if (deb >= DEB_LAST) begin
                            state     <= HELD;
                            key_valid <= 1'b1;
                            key_code  <= code;
                            digit_old <= digit_new;
                            digit_new <= code;
                        end else begin
                            deb <= deb + 21'd1;
                        end
                    end else begin
                        state <= SCAN;
                        rows  <= rows_next;
                        dwell <= 8'd0;
                    end
                end
                HELD: begin
                    if (col_s == 4'hF) begin
                        state <= RELEASE;
                        deb   <= 21'd0;
                    end
                end
                default: begin
                    if (col_s != 4'hF) begin
                        state <= HELD;
                    end else if (deb >= DEB_LAST) begin
                        state <= SCAN;
                        rows  <= rows_next;
                        dwell <= 8'd0;
                    end else begin
                        deb <= deb + 21'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_ctrl.sv
// tb/tb_keypad_ctrl.sv - directed bench for keypad_ctrl with a row-gated key model
module tb_keypad_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] columns;
    logic [3:0] rows;
    logic [3:0] key_code;
    logic       key_valid;
    logic [3:0] digit_new;
    logic [3:0] digit_old;

    logic [3:0] press_row = 4'b0000;
    logic [3:0] press_pat = 4'hF;
    logic       ovr       = 1'b0;
    logic [3:0] ovr_val   = 4'hF;

    int n_checks = 0;
    int n_fails  = 0;
    int kv_total = 0;
    int kv_mark;

    // A pressed key pulls its column low only while its row is driven.
    assign columns = ovr ? ovr_val : ((rows == press_row) ? press_pat : 4'hF);

    keypad_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
        .clk(clk), .reset(reset), .columns(columns), .rows(rows),
        .key_code(key_code), .key_valid(key_valid),
        .digit_new(digit_new), .digit_old(digit_old)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (key_valid === 1'b1) kv_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rows(input logic [3:0] r, input string tag);
        int n = 0;
        while (rows !== r && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, rows, r);
    endtask

    task automatic wait_kv(input string tag);
        int n = 0;
        while (key_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(tag, key_valid, 1'b1);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        cycles(3);
        chk("rst_rows", rows, 4'b1000);
        chk("rst_code", key_code, 4'h0);
        chk("rst_valid", key_valid, 1'b0);
        chk("rst_new", digit_new, 4'h0);
        chk("rst_old", digit_old, 4'h0);

        // Idle scan: four cycles per row, starting with a full row0 dwell.
        reset = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("scan_k%0d", k), rows, 4'b1000 >> ((k / 4) % 4));
        end
        cycles(200);
        chk("idle_no_kv", kv_total, 0);

        // Key 5: row1/col1.
        kv_mark   = kv_total;
        press_pat = 4'b1011;
        press_row = 4'b0100;
        wait_kv("k5_seen");
        chk("k5_code", key_code, 4'h5);
        chk("k5_new", digit_new, 4'h5);
        cycles(50);
        chk("k5_rows_frozen", rows, 4'b0100);
        press_row = 4'b0000;
        cycles(40);
        chk("k5_one_kv", kv_total - kv_mark, 1);

        // Key D: row3/col3.
        kv_mark   = kv_total;
        press_pat = 4'b1110;
        press_row = 4'b0001;
        wait_kv("kd_seen");
        chk("kd_code", key_code, 4'hD);
        chk("kd_new", digit_new, 4'hD);
        chk("kd_old", digit_old, 4'h5);
        cycles(30);
        press_row = 4'b0000;
        cycles(40);
        chk("kd_one_kv", kv_total - kv_mark, 1);

        // Short bounce on row0: three low cycles caught by the dwell sample.
        kv_mark = kv_total;
        wait_rows(4'b0001, "bn_find_r3");
        wait_rows(4'b1000, "bn_find_r0");
        @(negedge clk);
        ovr_val = 4'b0111;
        ovr     = 1'b1;
        cycles(3);
        ovr     = 1'b0;
        cycles(2);
        chk("bn_frozen", rows, 4'b1000);
        @(negedge clk);
        chk("bn_next_row", rows, 4'b0100);
        cycles(40);
        chk("bn_no_kv", kv_total - kv_mark, 0);

        // Two low columns on row0, then a short release glitch while held.
        kv_mark   = kv_total;
        press_pat = 4'b0011;
        press_row = 4'b1000;
        wait_kv("k1_seen");
        chk("k1_code", key_code, 4'h1);
        chk("k1_old", digit_old, 4'hD);
        cycles(10);
        press_pat = 4'hF;
        cycles(3);
        press_pat = 4'b0011;
        cycles(20);
        chk("k1_glitch_rows", rows, 4'b1000);
        press_row = 4'b0000;
        cycles(40);
        chk("k1_one_kv", kv_total - kv_mark, 1);

        // Reset in the middle of debouncing key 7 (row2/col0).
        kv_mark   = kv_total;
        press_pat = 4'b0111;
        press_row = 4'b0010;
        wait_rows(4'b0100, "mr_find_r1");
        wait_rows(4'b0010, "mr_find_r2");
        cycles(7);
        reset = 1'b0;
        #1;
        chk("mr_rows", rows, 4'b1000);
        chk("mr_code", key_code, 4'h0);
        chk("mr_valid", key_valid, 1'b0);
        chk("mr_new", digit_new, 4'h0);
        chk("mr_old", digit_old, 4'h0);
        cycles(5);
        press_row = 4'b0000;
        reset     = 1'b1;
        cycles(3);
        chk("mr_dwell_full", rows, 4'b1000);
        @(negedge clk);
        chk("mr_dwell_next", rows, 4'b0100);
        cycles(40);
        chk("mr_no_kv", kv_total - kv_mark, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
